// File: rtl/ms_txfifo_pkg.sv
// Register map, bit positions and data-phase record for the DMA TX FIFO.
package ms_txfifo_pkg;

  localparam logic [3:0] DATA_OFF   = 4'h0;
  localparam logic [3:0] STATUS_OFF = 4'h4;
  localparam logic [3:0] THRESH_OFF = 4'h8;
  localparam logic [3:0] CTRL_OFF   = 4'hC;

  localparam int EMPTY_BIT = 16;
  localparam int FULL_BIT  = 17;
  localparam int OVF_BIT   = 18;

  localparam int EN_BIT    = 0;
  localparam int FLUSH_BIT = 1;

  // Captured AHB address phase, acted on in the following data phase.
  typedef struct packed {
    logic       vld;
    logic       wr;
    logic [1:0] idx;
  } dphase_t;

endpackage

// File: rtl/ms_sync_fifo.sv
// First-word-fall-through synchronous FIFO with an extra pointer bit for
// full/empty disambiguation; flush wins over push/pop in the same cycle.
module ms_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [DW-1:0] rdata,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push, do_pop;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot a push to a full FIFO needs.
  assign do_push = push & (~full | pop) & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Next pointer values: flush collapses both to zero.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ms_ahbl_dma_txfifo.sv
// AHB-Lite DMA TX FIFO: register decode, DREQ, OVF and write-stall logic.
// Optional macro MS_TXFIFO_WR_STALL_EN: DATA writes to a full FIFO stall
// (HREADYOUT low) instead of being dropped with OVF set.
module ms_ahbl_dma_txfifo
  import ms_txfifo_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic          HREADY,
  input  logic [31:0]   HWDATA,
  input  logic [2:0]    HSIZE,
  output logic          HREADYOUT,
  output logic [31:0]   HRDATA,
  output logic          DREQ,
  output logic          S_VALID,
  output logic [DW-1:0] S_DATA,
  input  logic          S_READY
);

  localparam int AW = $clog2(DEPTH);

  dphase_t       dp_q, dp_d;
  logic          en_q, en_d;
  logic          ovf_q, ovf_d;
  logic          dreq_q, dreq_d;
  logic [8:0]    thresh_q, thresh_d;

  logic [AW:0]   level;
  logic          full, empty;
  logic [DW-1:0] head;
  logic [3:0]    dp_off;
  logic          wr_data, wr_status, wr_thresh, wr_ctrl;
  logic          push, pop, flush, ovf_set;
  logic [9:0]    lvl_nxt, free_nxt;
  logic          unused_ok;

  assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA};

  assign dp_off    = {dp_q.idx, 2'b00};
  assign wr_data   = dp_q.vld & dp_q.wr & (dp_off == DATA_OFF);
  assign wr_status = dp_q.vld & dp_q.wr & (dp_off == STATUS_OFF);
  assign wr_thresh = dp_q.vld & dp_q.wr & (dp_off == THRESH_OFF);
  assign wr_ctrl   = dp_q.vld & dp_q.wr & (dp_off == CTRL_OFF);

  assign S_VALID = en_q & ~empty;
  assign S_DATA  = empty ? '0 : head;
  assign DREQ    = dreq_q;
  assign pop     = S_VALID & S_READY;
  assign flush   = wr_ctrl & HWDATA[FLUSH_BIT];
  assign push    = wr_data & (~full | pop);

`ifdef MS_TXFIFO_WR_STALL_EN
  // Hold the data phase open until a pop makes room; never overflow.
  assign HREADYOUT = ~(wr_data & full & ~pop);
  assign ovf_set   = 1'b0;
`else
  assign HREADYOUT = 1'b1;
  assign ovf_set   = wr_data & full & ~pop;
`endif

  ms_sync_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (push),
    .wdata (HWDATA[DW-1:0]),
    .pop   (pop),
    .flush (flush),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Address-phase capture and register next-state, DREQ from post-update state.
  always_comb begin
    dp_d     = dp_q;
    en_d     = en_q;
    ovf_d    = ovf_q;
    thresh_d = thresh_q;
    if (HREADY) begin
      dp_d.vld = HSEL & HTRANS[1];
      dp_d.wr  = HWRITE;
      dp_d.idx = HADDR[3:2];
    end
    if (wr_ctrl) en_d = HWDATA[EN_BIT];
    if (wr_thresh)
      thresh_d = (HWDATA[8:0] > 9'(DEPTH)) ? 9'(DEPTH) : HWDATA[8:0];
    if (ovf_set)
      ovf_d = 1'b1;
    else if (wr_status & HWDATA[OVF_BIT])
      ovf_d = 1'b0;
    lvl_nxt  = flush ? 10'd0 : 10'(level) + 10'(push) - 10'(pop);
    free_nxt = 10'(DEPTH) - lvl_nxt;
    dreq_d   = en_d & (thresh_d != 9'd0) & (free_nxt >= {1'b0, thresh_d});
  end

  // Control/status registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_q     <= '0;
      en_q     <= 1'b0;
      ovf_q    <= 1'b0;
      dreq_q   <= 1'b0;
      thresh_q <= 9'(DEPTH / 2);
    end else begin
      dp_q     <= dp_d;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
      dreq_q   <= dreq_d;
      thresh_q <= thresh_d;
    end
  end

  // Read mux driven by the captured data-phase address.
  always_comb begin
    HRDATA = '0;
    if (dp_q.vld & ~dp_q.wr) begin
      case (dp_off)
        STATUS_OFF: begin
          HRDATA[AW:0]      = level;
          HRDATA[EMPTY_BIT] = empty;
          HRDATA[FULL_BIT]  = full;
          HRDATA[OVF_BIT]   = ovf_q;
        end
        THRESH_OFF: HRDATA[8:0]    = thresh_q;
        CTRL_OFF:   HRDATA[EN_BIT] = en_q;
        default:    HRDATA         = '0;
      endcase
    end
  end

endmodule
